// File: rtl/fifo_bram_grace_pkg.sv
// Shared definitions for the grace-window FWFT FIFO.
//  - ptr_t / ptr_inc : wide pointer type and wrap-around increment, so DEPTH need not be
//                      a power of two.
//  - flags_t         : registered status flags with their reset value.
//  - params_legal    : elaboration-time legality check of the parameter set.
package fifo_bram_grace_pkg;

    localparam int unsigned PTR_MAX_WIDTH = 16;

    typedef logic [PTR_MAX_WIDTH-1:0] ptr_t;

    typedef struct packed {
        logic full_n;
        logic empty_n;
        logic overflow;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{full_n: 1'b1, empty_n: 1'b0, overflow: 1'b0};

    // Increment with wrap from last back to zero.
    function automatic ptr_t ptr_inc(input ptr_t ptr, input ptr_t last);
        return (ptr == last) ? '0 : ptr + ptr_t'(1);
    endfunction

    function automatic logic params_legal(input int unsigned dw, input int unsigned aw,
                                          input int unsigned depth, input int unsigned grace);
        return (dw > 0) && (aw > 0) && (aw <= PTR_MAX_WIDTH) && (depth >= 2)
            && ((64'(1) << aw) >= 64'(depth)) && (grace < depth);
    endfunction

endpackage

// File: rtl/fifo_bram_sdp_ram.sv
// Simple dual-port RAM used as FIFO storage.
//  clk   : clock
//  we    : write enable
//  waddr : write address
//  din   : write data
//  raddr : read address, sampled every cycle
//  q     : read data, mem[raddr] one cycle after raddr is presented (read-before-write)
// Contents are not reset.
module fifo_bram_sdp_ram #(
    parameter string       MEM_STYLE  = "auto",
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] q
);

    (* ram_style = MEM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
        q <= mem[raddr];
    end

endmodule

// File: rtl/fifo_bram_grace.sv
// First-word fall-through FIFO on block RAM with an early-full grace window.
//  clk, reset   : clock, asynchronous active-high reset
//  if_full_n    : 0 once ram_used >= DEPTH-GRACE_PERIOD; writes still land until truly full
//  if_write_ce  : write-side clock enable
//  if_write     : write request
//  if_din       : write data
//  if_empty_n   : if_dout holds a valid word
//  if_read_ce   : read-side clock enable
//  if_read      : consume if_dout
//  if_dout      : head word
//  if_count     : words held (RAM plus output register)
//  if_overflow  : sticky, set when a write is dropped because the RAM is full
// Capacity is DEPTH words of RAM plus one word in the output register.
module fifo_bram_grace
    import fifo_bram_grace_pkg::*;
#(
    parameter string       MEM_STYLE    = "auto",
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned GRACE_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_overflow
);

    if (!params_legal(DATA_WIDTH, ADDR_WIDTH, DEPTH, GRACE_PERIOD)) begin : g_bad_params
        $error("fifo_bram_grace: illegal parameter combination");
    end

    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_THR = (ADDR_WIDTH + 1)'(DEPTH - GRACE_PERIOD);
    localparam logic [ADDR_WIDTH:0] ONE_W    = (ADDR_WIDTH + 1)'(1);
    localparam ptr_t                LAST_PTR = ptr_t'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH:0]   used_q, used_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    flags_t                flags_q, flags_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] bypass_q, bypass_d;
    logic                  use_bypass_q, use_bypass_d;

    logic                  wr_req;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] head;

    // RAM is addressed with the next read pointer, so its output already shows the new head
    // in the cycle after a pop.
    fifo_bram_sdp_ram #(
        .MEM_STYLE  (MEM_STYLE),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (waddr_q),
        .din   (if_din),
        .raddr (raddr_d),
        .q     (ram_q)
    );

    always_comb begin
        wr_req = if_write_ce & if_write;
        // Deliberately ignores if_full_n: the grace window stays writable.
        push   = (used_q != DEPTH_W) & wr_req;
        pop    = (used_q != '0) & if_read_ce & (~flags_q.empty_n | if_read);
        head   = use_bypass_q ? bypass_q : ram_q;
    end

    always_comb begin
        waddr_d = push ? ADDR_WIDTH'(ptr_inc(ptr_t'(waddr_q), LAST_PTR)) : waddr_q;
        raddr_d = pop  ? ADDR_WIDTH'(ptr_inc(ptr_t'(raddr_q), LAST_PTR)) : raddr_q;

        unique case ({push, pop})
            2'b10:   used_d = used_q + ONE_W;
            2'b01:   used_d = used_q - ONE_W;
            default: used_d = used_q;
        endcase

        // The word written now becomes the RAM head, but the RAM read issued this same cycle
        // returns the old contents; keep a copy to stand in for it.
        use_bypass_d = push & ((used_q == '0) | ((used_q == ONE_W) & pop));
        bypass_d     = use_bypass_d ? if_din : bypass_q;

        dout_d = pop ? head : dout_q;

        flags_d = flags_q;
        if (pop) begin
            flags_d.empty_n = 1'b1;
        end else if (if_read_ce & if_read) begin
            flags_d.empty_n = 1'b0;
        end
        flags_d.full_n   = (used_d < FULL_THR);
        flags_d.overflow = flags_q.overflow | (wr_req & (used_q == DEPTH_W));

        count_d = used_d + {{ADDR_WIDTH{1'b0}}, flags_d.empty_n};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waddr_q      <= '0;
            raddr_q      <= '0;
            used_q       <= '0;
            count_q      <= '0;
            flags_q      <= FLAGS_RESET;
            dout_q       <= '0;
            bypass_q     <= '0;
            use_bypass_q <= 1'b0;
        end else begin
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            used_q       <= used_d;
            count_q      <= count_d;
            flags_q      <= flags_d;
            dout_q       <= dout_d;
            bypass_q     <= bypass_d;
            use_bypass_q <= use_bypass_d;
        end
    end

    always_comb begin
        if_full_n   = flags_q.full_n;
        if_empty_n  = flags_q.empty_n;
        if_overflow = flags_q.overflow;
        if_dout     = dout_q;
        if_count    = count_q;
    end

endmodule

// File: tb/tb_fifo_bram_grace.sv
// Self-checking bench for fifo_bram_grace: a DEPTH=8 and a DEPTH=6 instance driven with
// the same inputs; a queue-based model of the selected instance checks every cycle.
module tb_fifo_bram_grace;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          we = 1'b0, wr = 1'b0, rce = 1'b0, rd = 1'b0;
    logic [DW-1:0] din = '0;

    logic          full_n8, empty_n8, ovf8, full_n6, empty_n6, ovf6;
    logic [DW-1:0] dout8, dout6;
    logic [3:0]    count8, count6;

    always #5 clk = ~clk;

    fifo_bram_grace #(
        .MEM_STYLE ("auto"), .DATA_WIDTH (DW), .ADDR_WIDTH (3), .DEPTH (8), .GRACE_PERIOD (2)
    ) dut8 (
        .clk (clk), .reset (reset), .if_full_n (full_n8), .if_write_ce (we), .if_write (wr),
        .if_din (din), .if_empty_n (empty_n8), .if_read_ce (rce), .if_read (rd),
        .if_dout (dout8), .if_count (count8), .if_overflow (ovf8)
    );

    fifo_bram_grace #(
        .MEM_STYLE ("auto"), .DATA_WIDTH (DW), .ADDR_WIDTH (3), .DEPTH (6), .GRACE_PERIOD (2)
    ) dut6 (
        .clk (clk), .reset (reset), .if_full_n (full_n6), .if_write_ce (we), .if_write (wr),
        .if_din (din), .if_empty_n (empty_n6), .if_read_ce (rce), .if_read (rd),
        .if_dout (dout6), .if_count (count6), .if_overflow (ovf6)
    );

    bit            sel = 1'b0;  // 0: dut8, 1: dut6
    logic          o_full_n, o_empty_n, o_ovf;
    logic [DW-1:0] o_dout;
    logic [3:0]    o_count;
    assign o_full_n  = sel ? full_n6  : full_n8;
    assign o_empty_n = sel ? empty_n6 : empty_n8;
    assign o_ovf     = sel ? ovf6     : ovf8;
    assign o_dout    = sel ? dout6    : dout8;
    assign o_count   = sel ? count6   : count8;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: RAM as a queue, output register as valid+data.
    int unsigned   m_depth = 8;
    int unsigned   m_grace = 2;
    logic [DW-1:0] m_ram[$];
    bit            m_valid;
    logic [DW-1:0] m_dout;
    bit            m_ovf;
    bit            m_full_n;

    function automatic void model_reset();
        m_ram.delete();
        m_valid  = 1'b0;
        m_dout   = '0;
        m_ovf    = 1'b0;
        m_full_n = 1'b1;
    endfunction

    function automatic void model_step();
        bit push, pop;
        push = (m_ram.size() != m_depth) && we && wr;
        pop  = (m_ram.size() != 0) && rce && (!m_valid || rd);
        if (we && wr && !push) m_ovf = 1'b1;
        if (pop) begin
            m_dout  = m_ram.pop_front();
            m_valid = 1'b1;
        end else if (rce && rd) begin
            m_valid = 1'b0;
        end
        if (push) m_ram.push_back(din);
        m_full_n = (m_ram.size() < m_depth - m_grace);
    endfunction

    task automatic compare_model(input string tag);
        chk({tag, ".full_n"},   32'(o_full_n),  32'(m_full_n));
        chk({tag, ".empty_n"},  32'(o_empty_n), 32'(m_valid));
        chk({tag, ".dout"},     o_dout,         m_dout);
        chk({tag, ".count"},    32'(o_count),   32'(m_ram.size()) + 32'(m_valid));
        chk({tag, ".overflow"}, 32'(o_ovf),     32'(m_ovf));
    endtask

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic step(input string tag, input bit wce, input bit w, input logic [DW-1:0] d,
                        input bit rc, input bit r);
        we = wce; wr = w; din = d; rce = rc; rd = r;
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset(input bit s, input int unsigned depth);
        sel = s; m_depth = depth;
        we = 0; wr = 0; din = '0; rce = 0; rd = 0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct packed {
        logic          wce;
        logic          w;
        logic [DW-1:0] din;
        logic          rce;
        logic          rd;
        logic          e_empty_n;
        logic [DW-1:0] e_dout;
        logic [4:0]    e_count;
        logic          e_full_n;
        logic          e_ovf;
    } vec_t;

    function automatic vec_t mk(input bit wce, input bit w, input int d, input bit rc,
                                input bit r, input bit e_empty_n, input int e_dout,
                                input int e_count, input bit e_full_n, input bit e_ovf);
        vec_t v;
        v.wce = wce; v.w = w; v.din = DW'(d); v.rce = rc; v.rd = r;
        v.e_empty_n = e_empty_n; v.e_dout = DW'(e_dout); v.e_count = 5'(e_count);
        v.e_full_n = e_full_n; v.e_ovf = e_ovf;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t          vecs[$];
        logic [DW-1:0] got[$];
        int unsigned   len, mode, pw, pr;
        bit            b_wce, b_w, b_rc, b_r;

        // Reset values
        do_reset(1'b0, 8);
        chk("reset.full_n",  32'(o_full_n),  32'd1);
        chk("reset.empty_n", 32'(o_empty_n), 32'd0);
        chk("reset.dout",    o_dout,         32'd0);
        chk("reset.count",   32'(o_count),   32'd0);
        chk("reset.ovf",     32'(o_ovf),     32'd0);

        // Tests 1 and 2 as vectors: expected outputs right after each edge.
        vecs.push_back(mk(1, 1, 1, 1, 0,  0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,  1, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,  0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 55, 1, 1, 0, 1, 0, 1, 0));  // ce low, read while empty
        for (int k = 1; k <= 6; k++) vecs.push_back(mk(1, 1, k, 0, 0, 0, 1, k, k < 6, 0));
        vecs.push_back(mk(1, 1, 7, 0, 0,  0, 1, 7, 0, 0));
        vecs.push_back(mk(1, 1, 8, 0, 0,  0, 1, 8, 0, 0));
        vecs.push_back(mk(1, 1, 9, 0, 0,  0, 1, 8, 0, 1));
        for (int j = 1; j <= 8; j++) vecs.push_back(mk(0, 0, 0, 1, 1, 1, j, 9 - j, (8 - j) < 6, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1,  0, 8, 0, 1, 1));

        foreach (vecs[i]) begin
            we = vecs[i].wce; wr = vecs[i].w; din = vecs[i].din;
            rce = vecs[i].rce; rd = vecs[i].rd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.empty_n", i), 32'(o_empty_n), 32'(vecs[i].e_empty_n));
            chk($sformatf("vec%0d.dout", i),    o_dout,         vecs[i].e_dout);
            chk($sformatf("vec%0d.count", i),   32'(o_count),   32'(vecs[i].e_count));
            chk($sformatf("vec%0d.full_n", i),  32'(o_full_n),  32'(vecs[i].e_full_n));
            chk($sformatf("vec%0d.ovf", i),     32'(o_ovf),     32'(vecs[i].e_ovf));
        end

        // Test 3: output register adds a ninth word; tenth is dropped; drain in order.
        do_reset(1'b0, 8);
        for (int k = 1; k <= 10; k++) step("t3.fill", 1, 1, DW'(k), 1, 0);
        chk("t3.count9", 32'(o_count), 32'd9);
        chk("t3.ovf",    32'(o_ovf),   32'd1);
        got.delete();
        for (int k = 0; k < 20 && o_empty_n; k++) begin
            got.push_back(o_dout);
            step("t3.drain", 0, 0, '0, 1, 1);
        end
        chk("t3.drained", 32'(got.size()), 32'd9);
        for (int k = 0; k < 9 && k < got.size(); k++) chk("t3.order", got[k], DW'(k + 1));

        // Test 4: steady write+read every cycle.
        do_reset(1'b0, 8);
        for (int i = 0; i < 100; i++) begin
            step("t4", 1, 1, DW'(i + 1), 1, 1);
            if (i >= 1) begin
                chk("t4.no_gap",   32'(o_empty_n), 32'd1);
                chk("t4.order",    o_dout,         DW'(i));
                chk("t4.count",    32'(o_count),   32'd2);
            end
        end

        // Test 5: random bursts on the non-power-of-two instance.
        do_reset(1'b1, 6);
        for (int b = 0; b < 20; b++) begin
            len  = $urandom_range(3, 12);
            mode = $urandom_range(0, 2);
            pw   = (mode == 0) ? 90 : (mode == 1) ? 20 : 50;
            pr   = (mode == 0) ? 20 : (mode == 1) ? 90 : 50;
            for (int c = 0; c < len; c++) begin
                b_wce = ($urandom_range(0, 99) < pw);
                b_w   = ($urandom_range(0, 99) < 90);
                b_rc  = ($urandom_range(0, 99) < pr);
                b_r   = ($urandom_range(0, 99) < 70);
                step($sformatf("t5.b%0d", b), b_wce, b_w, DW'($urandom), b_rc, b_r);
            end
        end

        // Test 6: asynchronous reset with 5 words held.
        do_reset(1'b0, 8);
        for (int k = 1; k <= 5; k++) step("t6.fill", 1, 1, DW'(k + 100), 1, 0);
        chk("t6.count_before", 32'(o_count), 32'd5);
        we = 0; wr = 0; rce = 0; rd = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6.async.empty_n", 32'(o_empty_n), 32'd0);
        chk("t6.async.count",   32'(o_count),   32'd0);
        chk("t6.async.full_n",  32'(o_full_n),  32'd1);
        chk("t6.async.dout",    o_dout,         32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step("t6.wr", 1, 1, 32'hABCD, 1, 0);
        step("t6.rd", 0, 0, '0, 1, 0);
        chk("t6.first.empty_n", 32'(o_empty_n), 32'd1);
        chk("t6.first.dout",    o_dout,         32'hABCD);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
